// File: rtl/mram_burst_bridge.sv
// Serial-command to asynchronous MRAM burst bridge: serially loads an address (and
// write data per word), runs fixed-length strobe accesses and streams read words out.
module mram_burst_bridge #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 20,
   parameter int BURST_W  = 4,
   parameter int WAIT_CYC = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_start,
   input  logic               cmd_rw,
   input  logic [1:0]         cmd_word_sel,
   input  logic [BURST_W-1:0] cmd_len,
   input  logic               ser_valid,
   input  logic               ser_addr_in,
   input  logic               ser_data_in,
   output logic               ser_data_out,
   output logic               ser_out_valid,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  mram_addr,
   output logic [DATA_W-1:0]  mram_dq_out,
   input  logic [DATA_W-1:0]  mram_dq_in,
   output logic               chip_en_n,
   output logic               write_en_n,
   output logic               out_en_n,
   output logic               lb_en_n,
   output logic               ub_en_n
);

   localparam int HALF    = DATA_W / 2;
   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ((ADDR_W > WAIT_CYC) ? ADDR_W : WAIT_CYC)
                                              : ((DATA_W > WAIT_CYC) ? DATA_W : WAIT_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_ADDR, LOAD_DATA, ACCESS, SHIFT_OUT, NEXT, DONE
   } state_t;

   state_t             state_q, state_d;
   logic               rw_q, rw_d;
   logic [1:0]         sel_q, sel_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] words_q, words_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [DATA_W-1:0]  lane_mask;
   logic               in_access;

   // Unselected byte lane is forced to zero before it reaches the serial output.
   always_comb begin
      case (sel_q)
         2'b01:   lane_mask = {{HALF{1'b0}}, {HALF{1'b1}}};
         2'b10:   lane_mask = {{HALF{1'b1}}, {HALF{1'b0}}};
         default: lane_mask = {DATA_W{1'b1}};
      endcase
   end

   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      sel_d   = sel_q;
      len_d   = len_q;
      words_d = words_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (cmd_start) begin
               rw_d    = cmd_rw;
               sel_d   = cmd_word_sel;
               len_d   = cmd_len;
               words_d = '0;
               cnt_d   = '0;
               state_d = LOAD_ADDR;
            end
         end
         LOAD_ADDR: begin
            if (ser_valid) begin
               addr_d = {addr_q[ADDR_W-2:0], ser_addr_in};
               if (cnt_q == ADDR_LAST) begin
                  cnt_d   = '0;
                  state_d = rw_q ? LOAD_DATA : ACCESS;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LOAD_DATA: begin
            if (ser_valid) begin
               wdata_d = {wdata_q[DATA_W-2:0], ser_data_in};
               if (cnt_q == DATA_LAST) begin
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ACCESS: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d = '0;
               if (rw_q) begin
                  state_d = NEXT;
               end else begin
                  rdata_d = mram_dq_in & lane_mask;
                  state_d = SHIFT_OUT;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SHIFT_OUT: begin
            rdata_d = rdata_q << 1;
            if (cnt_q == DATA_LAST) begin
               cnt_d   = '0;
               state_d = NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         NEXT: begin
            if (words_q == len_q) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               words_d = words_q + BURST_W'(1);
               state_d = rw_q ? LOAD_DATA : ACCESS;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         sel_q   <= 2'b00;
         len_q   <= '0;
         words_q <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         sel_q   <= sel_d;
         len_q   <= len_d;
         words_q <= words_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from the registered state, so they all release together.
   assign in_access     = (state_q == ACCESS);
   assign chip_en_n     = ~in_access;
   assign write_en_n    = ~(in_access & rw_q);
   assign out_en_n      = ~(in_access & ~rw_q);
   assign lb_en_n       = ~(in_access & (sel_q != 2'b10));
   assign ub_en_n       = ~(in_access & (sel_q != 2'b01));
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign ser_out_valid = (state_q == SHIFT_OUT);
   assign ser_data_out  = (state_q == SHIFT_OUT) ? rdata_q[DATA_W-1] : 1'b0;
   assign mram_addr     = addr_q;
   assign mram_dq_out   = wdata_q;

endmodule

// File: tb/tb_mram_burst_bridge.sv
// Directed bench for mram_burst_bridge with a small MRAM read model and an access/serial monitor.
module tb_mram_burst_bridge;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 20;
   localparam int BURST_W  = 4;
   localparam int WAIT_CYC = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               cmd_start;
   logic               cmd_rw;
   logic [1:0]         cmd_word_sel;
   logic [BURST_W-1:0] cmd_len;
   logic               ser_valid;
   logic               ser_addr_in;
   logic               ser_data_in;
   logic               ser_data_out;
   logic               ser_out_valid;
   logic               busy;
   logic               done;
   logic [ADDR_W-1:0]  mram_addr;
   logic [DATA_W-1:0]  mram_dq_out;
   logic [DATA_W-1:0]  mram_dq_in;
   logic               chip_en_n, write_en_n, out_en_n, lb_en_n, ub_en_n;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:1023];

   mram_burst_bridge #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .WAIT_CYC(WAIT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_rw(cmd_rw),
      .cmd_word_sel(cmd_word_sel), .cmd_len(cmd_len), .ser_valid(ser_valid),
      .ser_addr_in(ser_addr_in), .ser_data_in(ser_data_in), .ser_data_out(ser_data_out),
      .ser_out_valid(ser_out_valid), .busy(busy), .done(done), .mram_addr(mram_addr),
      .mram_dq_out(mram_dq_out), .mram_dq_in(mram_dq_in), .chip_en_n(chip_en_n),
      .write_en_n(write_en_n), .out_en_n(out_en_n), .lb_en_n(lb_en_n), .ub_en_n(ub_en_n)
   );

   always #5 clk = ~clk;

   assign mram_dq_in = mem[mram_addr[9:0]];

   // Monitor: records every strobe window and every received serial word.
   int          acc_n = 0;
   int          acc_len [0:63];
   logic [19:0] acc_addr [0:63];
   logic [15:0] acc_dq [0:63];
   logic [3:0]  acc_pat [0:63];
   bit          acc_unstable [0:63];
   bit          in_acc = 0;
   int          illegal = 0;
   int          done_cnt = 0;
   int          rx_n = 0;
   int          rx_bits = 0;
   logic [15:0] rx_shift = '0;
   logic [15:0] rx_word [0:63];

   always @(negedge clk) begin
      if (!write_en_n && !out_en_n) illegal++;
      if (chip_en_n && (!write_en_n || !out_en_n || !lb_en_n || !ub_en_n)) illegal++;
      if (!chip_en_n) begin
         if (!in_acc) begin
            acc_len[acc_n]      = 1;
            acc_addr[acc_n]     = mram_addr;
            acc_dq[acc_n]       = mram_dq_out;
            acc_pat[acc_n]      = {write_en_n, out_en_n, lb_en_n, ub_en_n};
            acc_unstable[acc_n] = 1'b0;
            acc_n++;
            in_acc = 1'b1;
         end else begin
            acc_len[acc_n-1]++;
            if (mram_addr !== acc_addr[acc_n-1] || mram_dq_out !== acc_dq[acc_n-1] ||
                {write_en_n, out_en_n, lb_en_n, ub_en_n} !== acc_pat[acc_n-1])
               acc_unstable[acc_n-1] = 1'b1;
         end
      end else begin
         in_acc = 1'b0;
      end
      if (done) done_cnt++;
      if (ser_out_valid) begin
         rx_shift = {rx_shift[14:0], ser_data_out};
         rx_bits++;
         if (rx_bits == 16) begin
            rx_word[rx_n] = rx_shift;
            rx_n++;
            rx_bits = 0;
         end
      end
   end

   // Stimulus drivers (all driving happens on the falling edge).
   task automatic issue_cmd(input logic rw, input logic [1:0] sel, input logic [BURST_W-1:0] len);
      @(negedge clk);
      cmd_start    = 1'b1;
      cmd_rw       = rw;
      cmd_word_sel = sel;
      cmd_len      = len;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic shift_addr(input logic [19:0] a, input bit gapped);
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         if (gapped) begin
            ser_valid   = 1'b0;
            ser_addr_in = ~a[i];
            cmd_start   = (i == 15 || i == 4);
            cmd_rw      = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
         end
         ser_valid   = 1'b1;
         ser_addr_in = a[i];
         @(negedge clk);
      end
      ser_valid = 1'b0;
   endtask

   task automatic shift_data(input logic [15:0] d);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         ser_valid   = 1'b1;
         ser_data_in = d[i];
         @(negedge clk);
      end
      ser_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ce(input logic level, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (chip_en_n === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({chip_en_n, write_en_n, out_en_n, lb_en_n, ub_en_n} !== 5'b11111) begin
         errors++;
         $display("[TB] FAIL reset_strobes got=%b want=11111",
                  {chip_en_n, write_en_n, out_en_n, lb_en_n, ub_en_n});
      end
      checks++;
      if ({busy, done, ser_out_valid, ser_data_out} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, ser_out_valid, ser_data_out});
      end
      checks++;
      if (mram_addr !== 20'h0 || mram_dq_out !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus addr=%h dq=%h want 0/0", mram_addr, mram_dq_out);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      bit ok;
      issue_cmd(1'b1, 2'b00, 4'd0);
      shift_addr(20'h00555, 1'b0);
      shift_data(16'h1234);
      wait_ce(1'b0, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL midrst_access_start got=timeout want=chip_en_n low");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({chip_en_n, write_en_n, out_en_n, lb_en_n, ub_en_n} !== 5'b11111) begin
         errors++;
         $display("[TB] FAIL midrst_strobes got=%b want=11111",
                  {chip_en_n, write_en_n, out_en_n, lb_en_n, ub_en_n});
      end
      checks++;
      if (busy !== 1'b0 || mram_addr !== 20'h0) begin
         errors++;
         $display("[TB] FAIL midrst_idle busy=%b addr=%h want 0/00000", busy, mram_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || chip_en_n !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_stays_idle busy=%b ce=%b want 0/1", busy, chip_en_n);
      end
   endtask

   task automatic test_single_write();
      bit ok;
      int a0 = acc_n;
      int d0 = done_cnt;
      issue_cmd(1'b1, 2'b00, 4'd0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wr_busy got=%b want=1", busy);
      end
      shift_addr(20'h00012, 1'b0);
      shift_data(16'hA5C3);
      wait_done(100, ok);
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wr_done got ok=%b busy=%b want 1/1", ok, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_idle busy=%b done=%b want 0/0", busy, done);
      end
      checks++;
      if (acc_n - a0 !== 1 || done_cnt - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL wr_counts accesses=%0d dones=%0d want 1/1", acc_n - a0, done_cnt - d0);
      end
      checks++;
      if (acc_len[a0] !== WAIT_CYC) begin
         errors++;
         $display("[TB] FAIL wr_wait got=%0d want=%0d", acc_len[a0], WAIT_CYC);
      end
      checks++;
      if (acc_addr[a0] !== 20'h00012 || acc_dq[a0] !== 16'hA5C3) begin
         errors++;
         $display("[TB] FAIL wr_bus addr=%h dq=%h want 00012/a5c3", acc_addr[a0], acc_dq[a0]);
      end
      checks++;
      if (acc_pat[a0] !== 4'b0100 || acc_unstable[a0]) begin
         errors++;
         $display("[TB] FAIL wr_strobes pat=%b unstable=%b want 0100/0", acc_pat[a0], acc_unstable[a0]);
      end
   endtask

   task automatic test_read_burst();
      bit ok;
      logic [15:0] exp_w [0:3];
      int a0 = acc_n;
      int r0 = rx_n;
      int d0 = done_cnt;
      exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
      issue_cmd(1'b0, 2'b00, 4'd3);
      shift_addr(20'h00100, 1'b0);
      wait_done(300, ok);
      @(negedge clk);
      checks++;
      if (!ok || acc_n - a0 !== 4 || rx_n - r0 !== 4 || done_cnt - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL rd_counts ok=%b accesses=%0d words=%0d dones=%0d want 1/4/4/1",
                  ok, acc_n - a0, rx_n - r0, done_cnt - d0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_addr[a0+i] !== 20'h00100 + 20'(i) || acc_pat[a0+i] !== 4'b1000 ||
             acc_len[a0+i] !== WAIT_CYC) begin
            errors++;
            $display("[TB] FAIL rd_access%0d addr=%h pat=%b len=%0d want %h/1000/%0d",
                     i, acc_addr[a0+i], acc_pat[a0+i], acc_len[a0+i], 20'h00100 + 20'(i), WAIT_CYC);
         end
         checks++;
         if (rx_word[r0+i] !== exp_w[i]) begin
            errors++;
            $display("[TB] FAIL rd_word%0d got=%h want=%h", i, rx_word[r0+i], exp_w[i]);
         end
      end
   endtask

   task automatic test_upper_byte_read();
      bit ok;
      int a0 = acc_n;
      int r0 = rx_n;
      issue_cmd(1'b0, 2'b10, 4'd0);
      shift_addr(20'h00200, 1'b0);
      wait_done(100, ok);
      @(negedge clk);
      checks++;
      if (!ok || acc_n - a0 !== 1 || rx_n - r0 !== 1) begin
         errors++;
         $display("[TB] FAIL ub_counts ok=%b accesses=%0d words=%0d want 1/1/1", ok, acc_n - a0, rx_n - r0);
      end
      checks++;
      if (acc_pat[a0] !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL ub_lanes got=%b want=1010", acc_pat[a0]);
      end
      checks++;
      if (rx_word[r0] !== 16'hBE00) begin
         errors++;
         $display("[TB] FAIL ub_data got=%h want=be00", rx_word[r0]);
      end
   endtask

   task automatic test_write_wrap();
      bit ok;
      int a0 = acc_n;
      int d0 = done_cnt;
      issue_cmd(1'b1, 2'b11, 4'd1);
      shift_addr(20'hFFFFF, 1'b0);
      shift_data(16'h0F0F);
      wait_ce(1'b0, 20, ok);
      if (ok) wait_ce(1'b1, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL wrap_first_access got=timeout want=strobe window");
      end
      @(negedge clk);
      shift_data(16'hF0F0);
      wait_done(100, ok);
      @(negedge clk);
      checks++;
      if (!ok || acc_n - a0 !== 2 || done_cnt - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL wrap_counts ok=%b accesses=%0d dones=%0d want 1/2/1", ok, acc_n - a0, done_cnt - d0);
      end
      checks++;
      if (acc_addr[a0] !== 20'hFFFFF || acc_dq[a0] !== 16'h0F0F) begin
         errors++;
         $display("[TB] FAIL wrap_word0 addr=%h dq=%h want fffff/0f0f", acc_addr[a0], acc_dq[a0]);
      end
      checks++;
      if (acc_addr[a0+1] !== 20'h00000 || acc_dq[a0+1] !== 16'hF0F0 || acc_pat[a0+1] !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL wrap_word1 addr=%h dq=%h pat=%b want 00000/f0f0/0100",
                  acc_addr[a0+1], acc_dq[a0+1], acc_pat[a0+1]);
      end
   endtask

   task automatic test_gapped_ignore();
      bit ok;
      int a0 = acc_n;
      int r0 = rx_n;
      int d0 = done_cnt;
      issue_cmd(1'b0, 2'b01, 4'd0);
      shift_addr(20'h002A5, 1'b1);
      wait_done(100, ok);
      repeat (30) @(negedge clk);
      checks++;
      if (!ok || acc_n - a0 !== 1 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gap_counts ok=%b accesses=%0d dones=%0d busy=%b want 1/1/1/0",
                  ok, acc_n - a0, done_cnt - d0, busy);
      end
      checks++;
      if (acc_addr[a0] !== 20'h002A5 || acc_pat[a0] !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL gap_access addr=%h pat=%b want 002a5/1001", acc_addr[a0], acc_pat[a0]);
      end
      checks++;
      if (rx_n - r0 !== 1 || rx_word[r0] !== 16'h0081) begin
         errors++;
         $display("[TB] FAIL gap_data words=%0d got=%h want 1/0081", rx_n - r0, rx_word[r0]);
      end
   endtask

   task automatic test_strobe_rules();
      checks++;
      if (illegal !== 0) begin
         errors++;
         $display("[TB] FAIL strobe_rules got=%0d violations want=0", illegal);
      end
   endtask

   initial begin
      rst          = 1'b1;
      cmd_start    = 1'b0;
      cmd_rw       = 1'b0;
      cmd_word_sel = 2'b00;
      cmd_len      = '0;
      ser_valid    = 1'b0;
      ser_addr_in  = 1'b0;
      ser_data_in  = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h100] = 16'h1111;
      mem[10'h101] = 16'h2222;
      mem[10'h102] = 16'h3333;
      mem[10'h103] = 16'h4444;
      mem[10'h200] = 16'hBEEF;
      mem[10'h2A5] = 16'h7E81;

      test_reset();
      test_reset_mid_access();
      test_single_write();
      test_read_burst();
      test_upper_byte_read();
      test_write_wrap();
      test_gapped_ignore();
      test_strobe_rules();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
